bus_dma_ctrl: RTL and testbench

//  Block-copy DMA engine and CPU bus arbiter. Shares the v65C02 system bus
//  (RAM, VRAM, BIOS read path) between the CPU and a DMA copier. Control

---
 rtl/bus_dma_pkg.sv | 39 +++
 rtl/bus_dma_ctrl_if.sv | 37 +++
 rtl/dma_addr_cnt.sv | 23 ++
 rtl/bus_dma_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_bus_dma_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_dma_pkg.sv
// Shared definitions for the bus DMA copier: register map, CTRL/STATUS bit
// positions and the copy-sequencer state encoding.
package bus_dma_pkg;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 8;

  localparam logic [3:0] REG_SRC_L  = 4'd0;
  localparam logic [3:0] REG_SRC_H  = 4'd1;
  localparam logic [3:0] REG_DST_L  = 4'd2;
  localparam logic [3:0] REG_DST_H  = 4'd3;
  localparam logic [3:0] REG_LEN_L  = 4'd4;
  localparam logic [3:0] REG_LEN_H  = 4'd5;
  localparam logic [3:0] REG_CTRL   = 4'd6;
  localparam logic [3:0] REG_STATUS = 4'd7;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_SRC_FIX  = 2;
  localparam int CTRL_DST_FIX  = 3;
  localparam int CTRL_CLR_DONE = 7;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_REL  = 3'd4
  } dma_state_e;

  // Byte lane of a 16-bit register as seen through the 8-bit register window.
  function automatic logic [7:0] byte_sel(input logic [15:0] v, input logic hi);
    return hi ? v[15:8] : v[7:0];
  endfunction

endpackage

// File: rtl/bus_dma_ctrl_if.sv
// Register window, CPU bus and arbitrated memory bus of the DMA copier.
interface bus_dma_ctrl_if;
  import bus_dma_pkg::*;

  // Register window
  logic              en_i;
  logic              we_i;
  logic [3:0]        addr_i;
  logic [BUS_DW-1:0] din_i;
  logic [BUS_DW-1:0] dout_o;

  // CPU side of the system bus
  logic [BUS_AW-1:0] cpu_addr_i;
  logic              cpu_we_i;
  logic [BUS_DW-1:0] cpu_dout_i;
  logic              cpu_rdy_o;

  // Arbitrated memory bus
  logic [BUS_DW-1:0] bus_din_i;
  logic [BUS_AW-1:0] bus_addr_o;
  logic              bus_we_o;
  logic [BUS_DW-1:0] bus_dout_o;

  logic              busy_o;
  logic              irq_o;

  modport slave (
    input  en_i, we_i, addr_i, din_i, cpu_addr_i, cpu_we_i, cpu_dout_i, bus_din_i,
    output dout_o, bus_addr_o, bus_we_o, bus_dout_o, cpu_rdy_o, busy_o, irq_o
  );

  modport master (
    output en_i, we_i, addr_i, din_i, cpu_addr_i, cpu_we_i, cpu_dout_i, bus_din_i,
    input  dout_o, bus_addr_o, bus_we_o, bus_dout_o, cpu_rdy_o, busy_o, irq_o
  );

endinterface

// File: rtl/dma_addr_cnt.sv
// Loadable up-counter used as a working address pointer; wraps modulo 2^W.
module dma_addr_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_o <= '0;
    end else if (load_i) begin
      cnt_o <= load_val_i;
    end else if (inc_i) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/bus_dma_ctrl.sv
// Block-copy DMA engine sharing the 65C02 system bus with the CPU. The CPU is
// held off with RDY while the copier owns the bus.
module bus_dma_ctrl
  import bus_dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  bus_dma_ctrl_if.slave        bus,
  output dma_state_e           dbg_state_o
);

  // Programmed registers
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [15:0]       len_q;
  logic              irq_en_q;
  logic              src_fix_q;
  logic              dst_fix_q;
  logic              done_q;

  // Working copy state
  dma_state_e        state_q, state_d;
  logic [15:0]       len_cnt_q;
  logic [ADDR_W-1:0] src_cnt;
  logic [ADDR_W-1:0] dst_cnt;
  logic              grant_q;
  logic              rdy_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rd_data;

  logic              reg_wr;
  logic              wr_ctrl;
  logic              start_ok;
  logic              clr_req;
  logic              len_zero;
  logic              copy_go;
  logic              last_byte;

  logic [ADDR_W-1:0] dma_addr;
  logic              dma_we;

  assign reg_wr    = bus.en_i & bus.we_i;
  assign wr_ctrl   = reg_wr && (bus.addr_i == REG_CTRL);
  assign clr_req   = wr_ctrl && bus.din_i[CTRL_CLR_DONE];
  assign start_ok  = wr_ctrl && bus.din_i[CTRL_START] && (state_q == ST_IDLE);
  assign len_zero  = (len_q == 16'd0);
  assign copy_go   = start_ok && !len_zero;
  assign last_byte = (len_cnt_q == 16'd1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      irq_en_q  <= 1'b0;
      src_fix_q <= 1'b0;
      dst_fix_q <= 1'b0;
    end else if (reg_wr) begin
      case (bus.addr_i)
        REG_SRC_L: src_q[7:0]  <= bus.din_i;
        REG_SRC_H: src_q[15:8] <= bus.din_i;
        REG_DST_L: dst_q[7:0]  <= bus.din_i;
        REG_DST_H: dst_q[15:8] <= bus.din_i;
        REG_LEN_L: len_q[7:0]  <= bus.din_i;
        REG_LEN_H: len_q[15:8] <= bus.din_i;
        REG_CTRL: begin
          irq_en_q  <= bus.din_i[CTRL_IRQ_EN];
          src_fix_q <= bus.din_i[CTRL_SRC_FIX];
          dst_fix_q <= bus.din_i[CTRL_DST_FIX];
        end
        default: ;
      endcase
    end
  end

  // Clear is applied before a coincident start, so a zero-length start still
  // leaves done set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_q <= 1'b0;
    end else if (state_q == ST_REL) begin
      done_q <= 1'b1;
    end else if (start_ok && len_zero) begin
      done_q <= 1'b1;
    end else if (clr_req) begin
      done_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (copy_go) state_d = ST_ARB;
      ST_ARB:  if (!bus.cpu_we_i) state_d = ST_RD;
      ST_RD:   state_d = ST_WR;
      ST_WR:   state_d = last_byte ? ST_REL : ST_RD;
      ST_REL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus ownership handshake: RDY drops the edge a copy is accepted; the grant
  // is only taken once the CPU is not mid-write, is released leaving REL, and
  // RDY returns one cycle after that so CPU and DMA never overlap on the bus.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      if (state_q == ST_ARB && state_d == ST_RD) begin
        grant_q <= 1'b1;
      end else if (state_q == ST_REL) begin
        grant_q <= 1'b0;
      end
      if (state_q == ST_IDLE) begin
        rdy_q <= !copy_go;
      end else begin
        rdy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      len_cnt_q <= '0;
    end else if (start_ok) begin
      len_cnt_q <= len_q;
    end else if (state_q == ST_WR) begin
      len_cnt_q <= len_cnt_q - 16'd1;
    end
  end

  dma_addr_cnt #(.W(ADDR_W)) u_src_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (start_ok),
    .load_val_i (src_q),
    .inc_i      ((state_q == ST_WR) && !src_fix_q),
    .cnt_o      (src_cnt)
  );

  dma_addr_cnt #(.W(ADDR_W)) u_dst_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (start_ok),
    .load_val_i (dst_q),
    .inc_i      ((state_q == ST_WR) && !dst_fix_q),
    .cnt_o      (dst_cnt)
  );

  assign dma_addr = (state_q == ST_WR) ? dst_cnt : src_cnt;
  assign dma_we   = (state_q == ST_WR);

  always_comb begin
    if (grant_q) begin
      bus.bus_addr_o = dma_addr;
      bus.bus_we_o   = dma_we;
      bus.bus_dout_o = bus.bus_din_i;
    end else begin
      bus.bus_addr_o = bus.cpu_addr_i;
      bus.bus_we_o   = bus.cpu_we_i;
      bus.bus_dout_o = bus.cpu_dout_i;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.addr_i)
      REG_SRC_L, REG_SRC_H: rd_data = byte_sel(src_q, bus.addr_i[0]);
      REG_DST_L, REG_DST_H: rd_data = byte_sel(dst_q, bus.addr_i[0]);
      REG_LEN_L, REG_LEN_H: rd_data = byte_sel(len_q, bus.addr_i[0]);
      REG_CTRL:   rd_data = {4'b0000, dst_fix_q, src_fix_q, irq_en_q, 1'b0};
      REG_STATUS: rd_data = {6'b000000, done_q, (state_q != ST_IDLE)};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dout_q <= '0;
    end else begin
      dout_q <= bus.en_i ? rd_data : '0;
    end
  end

  assign bus.dout_o    = dout_q;
  assign bus.cpu_rdy_o = rdy_q;
  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.irq_o     = done_q & irq_en_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bus_dma_ctrl.sv
// Directed bench for bus_dma_ctrl: a 64 KiB memory with one-cycle read latency
// sits on the arbitrated bus, the CPU is modelled by register/bus driver tasks.
module tb_bus_dma_ctrl;
  import bus_dma_pkg::*;

  localparam int WAIT_LIMIT = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_dma_ctrl_if bif ();
  dma_state_e dbg_state;

  bus_dma_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (bif),
    .dbg_state_o (dbg_state)
  );

  // Memory model: preload port has priority over bus writes
  logic [7:0]  mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [7:0]  pre_data = 8'h0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bif.bus_we_o) mem[bif.bus_addr_o] <= bif.bus_dout_o;
    bif.bus_din_i <= mem[bif.bus_addr_o];
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_idle();
    bif.en_i       = 1'b0;
    bif.we_i       = 1'b0;
    bif.addr_i     = 4'h0;
    bif.din_i      = 8'h00;
    bif.cpu_addr_i = 16'h0400;
    bif.cpu_we_i   = 1'b0;
    bif.cpu_dout_i = 8'h00;
  endtask

  task automatic reg_wr(input logic [3:0] idx, input logic [7:0] d);
    @(negedge clk);
    bif.en_i       = 1'b1;
    bif.we_i       = 1'b1;
    bif.addr_i     = idx;
    bif.din_i      = d;
    bif.cpu_addr_i = {12'hB00, idx};
    bif.cpu_we_i   = 1'b1;
    bif.cpu_dout_i = d;
    @(negedge clk);
    cpu_idle();
  endtask

  task automatic reg_rd(input logic [3:0] idx, output logic [7:0] d);
    @(negedge clk);
    bif.en_i       = 1'b1;
    bif.we_i       = 1'b0;
    bif.addr_i     = idx;
    bif.cpu_addr_i = {12'hB00, idx};
    @(posedge clk);
    #1;
    d = bif.dout_o;
    cpu_idle();
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic set_regs(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    reg_wr(REG_SRC_L, src[7:0]);
    reg_wr(REG_SRC_H, src[15:8]);
    reg_wr(REG_DST_L, dst[7:0]);
    reg_wr(REG_DST_H, dst[15:8]);
    reg_wr(REG_LEN_L, len[7:0]);
    reg_wr(REG_LEN_H, len[15:8]);
  endtask

  // Counts stalled cycles from the current negedge until RDY is back and idle
  task automatic wait_done(input string tag, output int stall);
    int n;
    stall = 0;
    n = 0;
    while ((!bif.cpu_rdy_o || bif.busy_o) && n < WAIT_LIMIT) begin
      if (!bif.cpu_rdy_o) stall++;
      n++;
      @(negedge clk);
    end
    check({tag, "_in_time"}, 32'(n < WAIT_LIMIT), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int stall;
    int low;
    int bad;

    // Reset values
    cpu_idle();
    bif.cpu_addr_i = 16'h1234;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy",      32'(bif.cpu_rdy_o),  32'd1);
    check("rst_busy",     32'(bif.busy_o),     32'd0);
    check("rst_irq",      32'(bif.irq_o),      32'd0);
    check("rst_bus_addr", 32'(bif.bus_addr_o), 32'h1234);
    check("rst_bus_we",   32'(bif.bus_we_o),   32'd0);
    check("rst_dout",     32'(bif.dout_o),     32'd0);
    check("rst_state",    32'(dbg_state),      32'(ST_IDLE));

    // Basic copy of 4 bytes RAM -> VRAM
    poke(16'h0100, 8'h11);
    poke(16'h0101, 8'h22);
    poke(16'h0102, 8'h33);
    poke(16'h0103, 8'h44);
    poke(16'h8004, 8'hEE);
    set_regs(16'h0100, 16'h8000, 16'h0004);
    reg_wr(REG_CTRL, 8'h01);
    check("copy_rdy_low_after_start", 32'(bif.cpu_rdy_o), 32'd0);
    wait_done("copy", stall);
    check("copy_stall", 32'(stall), 32'd11);
    check("copy_b0", 32'(mem[16'h8000]), 32'h11);
    check("copy_b1", 32'(mem[16'h8001]), 32'h22);
    check("copy_b2", 32'(mem[16'h8002]), 32'h33);
    check("copy_b3", 32'(mem[16'h8003]), 32'h44);
    check("copy_no_overrun", 32'(mem[16'h8004]), 32'hEE);
    reg_rd(REG_STATUS, rd);
    check("copy_status", 32'(rd), 32'h02);
    reg_rd(REG_SRC_H, rd);
    check("copy_src_h_kept", 32'(rd), 32'h01);
    reg_rd(REG_LEN_L, rd);
    check("copy_len_l_kept", 32'(rd), 32'h04);
    reg_rd(4'hC, rd);
    check("unmapped_reads_0", 32'(rd), 32'h00);

    // Fill with fixed source
    reg_wr(REG_CTRL, 8'h80);
    reg_rd(REG_STATUS, rd);
    check("clr_done_status", 32'(rd), 32'h00);
    poke(16'h0200, 8'h41);
    poke(16'h0201, 8'h99);
    poke(16'h8800, 8'hEE);
    set_regs(16'h0200, 16'h8000, 16'h0800);
    reg_wr(REG_CTRL, 8'h05);
    wait_done("fill", stall);
    check("fill_stall", 32'(stall), 32'd4099);
    bad = 0;
    for (int a = 16'h8000; a < 16'h8800; a++) begin
      if (mem[a] !== 8'h41) bad++;
    end
    check("fill_bad_bytes", 32'(bad), 32'd0);
    check("fill_no_overrun", 32'(mem[16'h8800]), 32'hEE);
    reg_rd(REG_SRC_H, rd);
    check("fill_src_h", 32'(rd), 32'h02);
    reg_rd(REG_CTRL, rd);
    check("fill_ctrl_readback", 32'(rd), 32'h04);

    // Zero length: done without stalling
    reg_wr(REG_CTRL, 8'h80);
    reg_wr(REG_LEN_L, 8'h00);
    reg_wr(REG_LEN_H, 8'h00);
    reg_wr(REG_CTRL, 8'h01);
    low = 0;
    repeat (4) begin
      if (!bif.cpu_rdy_o || bif.busy_o) low++;
      @(negedge clk);
    end
    check("len0_no_stall", 32'(low), 32'd0);
    reg_rd(REG_STATUS, rd);
    check("len0_status", 32'(rd), 32'h02);

    // Destination wrap, with clear+start in one write while done is set
    poke(16'h0500, 8'hA1);
    poke(16'h0501, 8'hA2);
    poke(16'h0502, 8'hA3);
    poke(16'h0001, 8'hEE);
    poke(16'hFFFD, 8'hEE);
    set_regs(16'h0500, 16'hFFFE, 16'h0003);
    reg_wr(REG_CTRL, 8'h81);
    reg_rd(REG_STATUS, rd);
    check("wrap_status_busy", 32'(rd), 32'h01);
    wait_done("wrap", stall);
    check("wrap_fffe", 32'(mem[16'hFFFE]), 32'hA1);
    check("wrap_ffff", 32'(mem[16'hFFFF]), 32'hA2);
    check("wrap_0000", 32'(mem[16'h0000]), 32'hA3);
    check("wrap_0001", 32'(mem[16'h0001]), 32'hEE);
    check("wrap_fffd", 32'(mem[16'hFFFD]), 32'hEE);

    // CPU write in the arbitration cycle delays the grant by one cycle
    poke(16'h0600, 8'h05);
    poke(16'h0601, 8'h06);
    poke(16'h0300, 8'h00);
    set_regs(16'h0600, 16'h8100, 16'h0002);
    reg_wr(REG_CTRL, 8'h01);
    bif.cpu_addr_i = 16'h0300;
    bif.cpu_we_i   = 1'b1;
    bif.cpu_dout_i = 8'h5A;
    #1;
    check("arb_state", 32'(dbg_state), 32'(ST_ARB));
    check("arb_cpu_addr_passes", 32'(bif.bus_addr_o), 32'h0300);
    check("arb_cpu_we_passes", 32'(bif.bus_we_o), 32'd1);
    @(negedge clk);
    cpu_idle();
    #1;
    check("arb_waited", 32'(dbg_state), 32'(ST_ARB));
    wait_done("arb", stall);
    check("arb_total_stall", 32'(stall + 1), 32'd8);
    check("arb_cpu_write_landed", 32'(mem[16'h0300]), 32'h5A);
    check("arb_b0", 32'(mem[16'h8100]), 32'h05);
    check("arb_b1", 32'(mem[16'h8101]), 32'h06);

    // IRQ follows done while enabled
    reg_wr(REG_CTRL, 8'h80);
    poke(16'h0700, 8'h77);
    set_regs(16'h0700, 16'h8200, 16'h0001);
    reg_wr(REG_CTRL, 8'h03);
    check("irq_low_during_copy", 32'(bif.irq_o), 32'd0);
    wait_done("irq", stall);
    check("irq_stall", 32'(stall), 32'd5);
    check("irq_high_after", 32'(bif.irq_o), 32'd1);
    check("irq_copy_byte", 32'(mem[16'h8200]), 32'h77);
    reg_wr(REG_CTRL, 8'h82);
    check("irq_cleared", 32'(bif.irq_o), 32'd0);

    // Reset in the middle of a long copy
    set_regs(16'h0700, 16'h9000, 16'h0100);
    reg_wr(REG_CTRL, 8'h01);
    repeat (20) @(negedge clk);
    check("midcopy_busy", 32'(bif.busy_o), 32'd1);
    check("midcopy_rdy", 32'(bif.cpu_rdy_o), 32'd0);
    bif.cpu_addr_i = 16'h4321;
    rst_n = 1'b0;
    #1;
    check("abort_rdy", 32'(bif.cpu_rdy_o), 32'd1);
    check("abort_bus_addr", 32'(bif.bus_addr_o), 32'h4321);
    check("abort_bus_we", 32'(bif.bus_we_o), 32'd0);
    check("abort_busy", 32'(bif.busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_idle();
    reg_rd(REG_STATUS, rd);
    check("abort_status", 32'(rd), 32'h00);
    reg_rd(REG_LEN_H, rd);
    check("abort_len_h_reset", 32'(rd), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
